// File: rtl/branch_resolve_bht_if.sv
// branch_resolve_bht_if: IF lookup (if_pc/if_pred_taken) plus EX resolve inputs and registered redirect/count outputs
interface branch_resolve_bht_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc;
  logic if_pred_taken;
  logic ex_valid;
  logic ex_is_branch;
  logic [2:0] ex_funct3;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic ex_pred_taken;
  logic mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic resolved_taken;
  logic illegal_branch;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_rs1_data, ex_rs2_data, ex_pc, ex_imm, ex_pred_taken,
    input if_pred_taken, mispredict, redirect_pc, resolved_taken, illegal_branch, branch_count, mispredict_count
  );
  modport slave (
    input if_pc, ex_valid, ex_is_branch, ex_funct3, ex_rs1_data, ex_rs2_data, ex_pc, ex_imm, ex_pred_taken,
    output if_pred_taken, mispredict, redirect_pc, resolved_taken, illegal_branch, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: RV32 branch resolver with 2-bit BHT predictor, mispredict redirect and counters; ports clk, reset, bus (slave)
module branch_resolve_bht #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input logic clk,
  input logic reset,
  branch_resolve_bht_if.slave bus
);
  logic [1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0] ex_idx;
  logic [1:0] ctr, ctr_next;
  logic acc, legal, base, taken, mp;
  logic unused_pc;
  assign unused_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};
  assign bus.if_pred_taken = bht[bus.if_pc[IDX_W+1:2]][1];
  always_comb begin
    ex_idx = bus.ex_pc[IDX_W+1:2];
    ctr = bht[ex_idx];
    acc = bus.ex_valid & bus.ex_is_branch & ~bus.mispredict;
    legal = ~(bus.ex_funct3[2:1] == 2'b01);
    base = ~bus.ex_funct3[2] ? (bus.ex_rs1_data == bus.ex_rs2_data) :
           ~bus.ex_funct3[1] ? ($signed(bus.ex_rs1_data) < $signed(bus.ex_rs2_data)) :
                               (bus.ex_rs1_data < bus.ex_rs2_data);
    taken = legal & (base ^ bus.ex_funct3[0]);
    mp = acc & legal & (taken ^ bus.ex_pred_taken);
    ctr_next = taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1) : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      bus.mispredict <= 1'b0;
      bus.redirect_pc <= '0;
      bus.resolved_taken <= 1'b0;
      bus.illegal_branch <= 1'b0;
      bus.branch_count <= '0;
      bus.mispredict_count <= '0;
    end else begin
      bus.mispredict <= mp;
      bus.illegal_branch <= acc & ~legal;
      if (acc) bus.resolved_taken <= taken;
      if (mp) bus.redirect_pc <= taken ? bus.ex_pc + bus.ex_imm : bus.ex_pc + XLEN'(4);
      if (mp) bus.mispredict_count <= bus.mispredict_count + 32'd1;
      if (acc & legal) begin
        bht[ex_idx] <= ctr_next;
        bus.branch_count <= bus.branch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: scoreboard bench for branch_resolve_bht
module tb_branch_resolve_bht;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  branch_resolve_bht_if #(.XLEN(32)) bus();
  branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic mp;
    logic [31:0] red;
    logic res;
    logic ill;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;
  exp_t sb[$];
  logic [1:0] m_bht [64];
  logic m_mp, m_res, m_ill;
  logic [31:0] m_red, m_bc, m_mc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_mp = 0; m_res = 0; m_ill = 0; m_red = 0; m_bc = 0; m_mc = 0;
    sb.delete();
  endtask
  task automatic step(input logic v, input logic br, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    exp_t e, g;
    logic acc, legal, t, mpn;
    logic [5:0] idx;
    logic [1:0] c;
    bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_funct3 = f3;
    bus.ex_rs1_data = a; bus.ex_rs2_data = b; bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_pred_taken = pred;
    #1;
    idx = bus.if_pc[7:2];
    chk("if_pred", {31'd0, bus.if_pred_taken}, {31'd0, m_bht[idx][1]});
    acc = v & br & ~m_mp;
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    t = legal & br_taken(f3, a, b);
    mpn = acc & legal & (t != pred);
    m_ill = acc & ~legal;
    if (acc) m_res = t;
    if (mpn) m_red = t ? pc + imm : pc + 32'd4;
    if (mpn) m_mc++;
    if (acc & legal) begin
      idx = pc[7:2];
      c = m_bht[idx];
      if (t) c = (c == 2'b11) ? c : c + 2'd1;
      else c = (c == 2'b00) ? c : c - 2'd1;
      m_bht[idx] = c;
      m_bc++;
    end
    m_mp = mpn;
    e = '{mp: m_mp, red: m_red, res: m_res, ill: m_ill, bc: m_bc, mc: m_mc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("mispredict", {31'd0, bus.mispredict}, {31'd0, g.mp});
    chk("redirect_pc", bus.redirect_pc, g.red);
    chk("resolved_taken", {31'd0, bus.resolved_taken}, {31'd0, g.res});
    chk("illegal_branch", {31'd0, bus.illegal_branch}, {31'd0, g.ill});
    chk("branch_count", bus.branch_count, g.bc);
    chk("mispredict_count", bus.mispredict_count, g.mc);
  endtask
  task automatic idle();
    step(0, 0, 3'b000, 0, 0, 32'h0, 0, 0);
  endtask
  task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    step(1, 1, f3, a, b, pc, imm, pred);
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_mp"}, {31'd0, bus.mispredict}, 32'd0);
    chk({tag, "_red"}, bus.redirect_pc, 32'd0);
    chk({tag, "_res"}, {31'd0, bus.resolved_taken}, 32'd0);
    chk({tag, "_ill"}, {31'd0, bus.illegal_branch}, 32'd0);
    chk({tag, "_bc"}, bus.branch_count, 32'd0);
    chk({tag, "_mc"}, bus.mispredict_count, 32'd0);
  endtask
  initial begin
    reset = 1;
    bus.if_pc = 0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_funct3 = 0;
    bus.ex_rs1_data = 0; bus.ex_rs2_data = 0; bus.ex_pc = 0; bus.ex_imm = 0; bus.ex_pred_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check_all_zero("reset");
    for (int i = 0; i < 64; i++) begin
      bus.if_pc = 32'(i * 4);
      #1 chk("reset_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    end
    bus.if_pc = 32'h100;
    br(3'b000, 10, 10, 32'h100, 32'h20, 0);
    chk("beq_redirect", bus.redirect_pc, 32'h120);
    chk("beq_mc", bus.mispredict_count, 32'd1);
    #1 chk("beq_pred_after", {31'd0, bus.if_pred_taken}, 32'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      br(3'b000, 10, 10, 32'h100, 32'h20, m_bht[0][1]);
      idle();
    end
    chk("beq_sat", {30'd0, m_bht[0]}, 32'd3);
    bus.if_pc = 32'h40;
    br(3'b100, -32'sd5, 32'd3, 32'h40, 32'h10, 1);
    chk("blt_taken", {31'd0, bus.resolved_taken}, 32'd1);
    br(3'b110, 32'h2, 32'hFFFFFFF0, 32'h44, 32'h30, 0);
    chk("bltu_redirect", bus.redirect_pc, 32'h74);
    idle();
    br(3'b111, 32'h2, 32'hFFFFFFF0, 32'h48, 32'h30, 1);
    chk("bgeu_redirect", bus.redirect_pc, 32'h4C);
    chk("bgeu_taken", {31'd0, bus.resolved_taken}, 32'd0);
    idle();
    br(3'b101, 32'h7, 32'h7, 32'h50, 32'h8, 1);
    bus.if_pc = 32'h308;
    br(3'b001, 1, 2, 32'h204, 32'h40, 0);
    br(3'b000, 5, 5, 32'h308, 32'h40, 0);
    chk("shadow_mp_drop", {31'd0, bus.mispredict}, 32'd0);
    chk("shadow_bht", {30'd0, m_bht[2]}, 32'd1);
    idle();
    br(3'b010, 1, 1, 32'h60, 32'h8, 0);
    chk("illegal_pulse", {31'd0, bus.illegal_branch}, 32'd1);
    idle();
    br(3'b011, 1, 2, 32'h64, 32'h8, 1);
    idle();
    bus.if_pc = 32'h14;
    br(3'b000, 3, 3, 32'h14, 32'h8, 0);
    #1 chk("collide_after", {31'd0, bus.if_pred_taken}, 32'd1);
    idle();
    br(3'b000, 9, 9, 32'hFFFFFFFC, 32'h8, 0);
    chk("wrap_redirect", bus.redirect_pc, 32'h4);
    idle();
    br(3'b001, 1, 2, 32'h80, 32'h10, 0);
    chk("pre_reset_mp", {31'd0, bus.mispredict}, 32'd1);
    reset = 1;
    bus.ex_valid = 1; bus.ex_is_branch = 1; bus.ex_funct3 = 3'b001; bus.ex_pred_taken = 0;
    @(posedge clk);
    #1;
    reset = 0;
    check_all_zero("mid_reset");
    model_reset();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
